sel_decoder_seq: RTL and testbench

Parametrised, registered one-hot select decoder for the register-file select path. It supports single-cycle decode of a register index. It also has a sweep mode that walks a contiguous, wrap-around range of one-hot selects, one per clock, for register-file clear and dump sequences. It sits between the control unit and the register-file enable lines and replaces the fixed 4-to-16 combinational decode.

---
 rtl/sel_decoder_seq.sv | 136 +++++++++++++
 tb/tb_sel_decoder_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sel_decoder_seq.sv
// sel_decoder_seq: registered one-hot select decoder with an optional wrap-around sweep mode.
// Sweep mode is built only when SEL_DECODER_SWEEP_EN is defined.
`default_nettype none

module sel_decoder_seq #(
    parameter  int SEL_W = 4,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    input  logic             sweep_start,
    input  logic [SEL_W-1:0] sweep_first,
    input  logic [SEL_W-1:0] sweep_last,
    input  logic             abort,
    output logic [OUT_W-1:0] out,
    output logic             valid,
    output logic [SEL_W-1:0] idx,
    output logic             busy,
    output logic             done
);

    // What an idle decoder would load on this edge. The final sweep element reuses it
    // so a new request is taken with no bubble.
    logic [SEL_W-1:0] acc_idx;
    logic [OUT_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_sweep;
    logic             acc_done;

    always_comb begin
        acc_idx   = '0;
        acc_valid = 1'b0;
        acc_sweep = 1'b0;
        acc_done  = 1'b0;
`ifdef SEL_DECODER_SWEEP_EN
        if (sweep_start) begin
            acc_idx   = sweep_first;
            acc_valid = 1'b1;
            acc_sweep = 1'b1;
            acc_done  = (sweep_first == sweep_last);
        end else if (en) begin
            acc_idx   = sel;
            acc_valid = 1'b1;
        end
`else
        if (en) begin
            acc_idx   = sel;
            acc_valid = 1'b1;
        end
`endif
    end

    assign acc_out = acc_valid ? (OUT_W'(1) << acc_idx) : '0;

`ifdef SEL_DECODER_SWEEP_EN
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] last_r;
    logic [SEL_W-1:0] next_idx;

    assign next_idx = SEL_W'(idx + 1'b1);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            last_r <= '0;
            out    <= '0;
            idx    <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                SWEEP: begin
                    if (abort) begin
                        state <= IDLE;
                        out   <= '0;
                        idx   <= '0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (idx != last_r) begin
                        idx  <= next_idx;
                        out  <= OUT_W'(1) << next_idx;
                        done <= (next_idx == last_r);
                    end else begin
                        state <= acc_sweep ? SWEEP : IDLE;
                        if (acc_sweep) last_r <= sweep_last;
                        out   <= acc_out;
                        idx   <= acc_idx;
                        valid <= acc_valid;
                        busy  <= acc_sweep;
                        done  <= acc_done;
                    end
                end
                default: begin
                    state <= acc_sweep ? SWEEP : IDLE;
                    if (acc_sweep) last_r <= sweep_last;
                    out   <= acc_out;
                    idx   <= acc_idx;
                    valid <= acc_valid;
                    busy  <= acc_sweep;
                    done  <= acc_done;
                end
            endcase
        end
    end
`else
    logic unused_sweep_inputs;
    assign unused_sweep_inputs = ^{sweep_start, sweep_first, sweep_last, abort, acc_sweep, acc_done};

    assign busy = 1'b0;
    assign done = 1'b0;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            out   <= '0;
            idx   <= '0;
            valid <= 1'b0;
        end else begin
            out   <= acc_out;
            idx   <= acc_idx;
            valid <= acc_valid;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sel_decoder_seq.sv
// tb_sel_decoder_seq: directed self-checking bench for sel_decoder_seq (SEL_W=4).
// Sweep vectors run only when SEL_DECODER_SWEEP_EN is defined.
`default_nettype none

module tb_sel_decoder_seq;

    logic        clk;
    logic        clr;
    logic        en;
    logic [3:0]  sel;
    logic        sweep_start;
    logic [3:0]  sweep_first;
    logic [3:0]  sweep_last;
    logic        abort;
    logic [15:0] out;
    logic        valid;
    logic [3:0]  idx;
    logic        busy;
    logic        done;

    int passed = 0;
    int total  = 0;

    sel_decoder_seq #(.SEL_W(4)) dut (
        .clk         (clk),
        .clr         (clr),
        .en          (en),
        .sel         (sel),
        .sweep_start (sweep_start),
        .sweep_first (sweep_first),
        .sweep_last  (sweep_last),
        .abort       (abort),
        .out         (out),
        .valid       (valid),
        .idx         (idx),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic expect_all(input string tag, input logic [15:0] e_out, input logic [3:0] e_idx,
                              input logic e_valid, input logic e_busy, input logic e_done);
        check({tag, ".out"},   32'(out),   32'(e_out));
        check({tag, ".idx"},   32'(idx),   32'(e_idx));
        check({tag, ".valid"}, 32'(valid), 32'(e_valid));
        check({tag, ".busy"},  32'(busy),  32'(e_busy));
        check({tag, ".done"},  32'(done),  32'(e_done));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; en = 1'b0; sel = '0; sweep_start = 1'b0;
        sweep_first = '0; sweep_last = '0; abort = 1'b0;
        #2;
        expect_all("reset", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        clr = 1'b0;

        // single decode, one cycle wide
        en = 1'b1; sel = 4'd5;
        tick();
        en = 1'b0;
        expect_all("dec5", 16'h0020, 4'd5, 1'b1, 1'b0, 1'b0);
        tick();
        expect_all("dec5_off", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

        // en held high decodes every cycle
        en = 1'b1; sel = 4'd3;
        tick();
        expect_all("hold3", 16'h0008, 4'd3, 1'b1, 1'b0, 1'b0);
        sel = 4'd12;
        tick();
        expect_all("hold12", 16'h1000, 4'd12, 1'b1, 1'b0, 1'b0);
        sel = 4'd0;
        tick();
        expect_all("hold0", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0);

        // asynchronous clear between edges
        sel = 4'd10;
        tick();
        check("pre_clr.out", 32'(out), 32'h0400);
        en = 1'b0;
        #2 clr = 1'b1;
        #1;
        expect_all("async_clr", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
        #1 clr = 1'b0;

`ifndef SEL_DECODER_SWEEP_EN
        // sweep controls have no effect in this build
        sweep_start = 1'b1; sweep_first = 4'd2; sweep_last = 4'd5;
        tick();
        expect_all("nosweep", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_all("nosweep2", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
        en = 1'b1; sel = 4'd15; abort = 1'b1;
        tick();
        expect_all("nosweep_dec15", 16'h8000, 4'd15, 1'b1, 1'b0, 1'b0);
        en = 1'b0; sweep_start = 1'b0; abort = 1'b0;
        tick();
        expect_all("nosweep_idle", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
`else
        // sweep 3..6
        sweep_start = 1'b1; sweep_first = 4'd3; sweep_last = 4'd6;
        tick();
        sweep_start = 1'b0; sweep_last = 4'd0;
        expect_all("sw36_0", 16'h0008, 4'd3, 1'b1, 1'b1, 1'b0);
        tick();
        expect_all("sw36_1", 16'h0010, 4'd4, 1'b1, 1'b1, 1'b0);
        tick();
        expect_all("sw36_2", 16'h0020, 4'd5, 1'b1, 1'b1, 1'b0);
        tick();
        expect_all("sw36_3", 16'h0040, 4'd6, 1'b1, 1'b1, 1'b1);
        tick();
        expect_all("sw36_end", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

        // wrap sweep 14..1 with en held; en then taken with no bubble
        sweep_start = 1'b1; sweep_first = 4'd14; sweep_last = 4'd1; en = 1'b1; sel = 4'd9;
        tick();
        sweep_start = 1'b0;
        expect_all("wrap_0", 16'h4000, 4'd14, 1'b1, 1'b1, 1'b0);
        tick();
        expect_all("wrap_1", 16'h8000, 4'd15, 1'b1, 1'b1, 1'b0);
        tick();
        expect_all("wrap_2", 16'h0001, 4'd0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_all("wrap_3", 16'h0002, 4'd1, 1'b1, 1'b1, 1'b1);
        tick();
        expect_all("wrap_b2b", 16'h0200, 4'd9, 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        tick();
        expect_all("wrap_idle", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

        // full sweep 0..15 aborted after the third element
        sweep_start = 1'b1; sweep_first = 4'd0; sweep_last = 4'd15;
        tick();
        sweep_start = 1'b0;
        expect_all("ab_0", 16'h0001, 4'd0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_all("ab_1", 16'h0002, 4'd1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_all("ab_2", 16'h0004, 4'd2, 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_all("ab_end", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

        // single-element sweep
        sweep_start = 1'b1; sweep_first = 4'd7; sweep_last = 4'd7;
        tick();
        sweep_start = 1'b0;
        expect_all("one_0", 16'h0080, 4'd7, 1'b1, 1'b1, 1'b1);
        tick();
        expect_all("one_end", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

        // back-to-back sweeps: second starts on the edge ending the first
        sweep_start = 1'b1; sweep_first = 4'd8; sweep_last = 4'd9;
        tick();
        sweep_first = 4'd2; sweep_last = 4'd2;
        expect_all("b2b_0", 16'h0100, 4'd8, 1'b1, 1'b1, 1'b0);
        tick();
        expect_all("b2b_1", 16'h0200, 4'd9, 1'b1, 1'b1, 1'b1);
        tick();
        sweep_start = 1'b0;
        expect_all("b2b_2", 16'h0004, 4'd2, 1'b1, 1'b1, 1'b1);
        tick();
        expect_all("b2b_end", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

        // clear mid-sweep discards it
        sweep_start = 1'b1; sweep_first = 4'd4; sweep_last = 4'd3;
        tick();
        sweep_start = 1'b0;
        tick();
        expect_all("clr_sw_1", 16'h0020, 4'd5, 1'b1, 1'b1, 1'b0);
        #2 clr = 1'b1;
        #1;
        expect_all("clr_sw", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
        #1 clr = 1'b0;
        tick();
        expect_all("clr_sw_after", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
